// File: rtl/run_ctrl.sv
// Run/stop and clear controller for a ticking counter: debounces two push-buttons,
// runs a two-state FSM and a pausable prescaler, and emits registered control pulses.
module run_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_run_n,
  input  logic key_clr_n,
  output logic tick_en,
  output logic clr_n,
  output logic conv_start,
  output logic running
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int PS_W  = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DB_CYCLES - 2);
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(TICK_DIV - 1);

  typedef enum logic {STOP, RUN} state_t;

  logic [1:0] keys;
  logic [1:0] press;

  assign keys = {key_clr_n, key_run_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic             sync_p0;
    logic             sync_p1;
    logic             samp;
    logic             level;
    logic             level_d;
    logic             press_r;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_p0 <= 1'b1;
        sync_p1 <= 1'b1;
        samp    <= 1'b1;
        level   <= 1'b1;
        level_d <= 1'b1;
        press_r <= 1'b0;
        cnt     <= '0;
      end else begin
        // synchronizer boundary: sync_p0 -> sync_p1, then one-cycle sample for change detection
        sync_p0 <= keys[k];
        sync_p1 <= sync_p0;
        samp    <= sync_p1;
        level_d <= level;
        press_r <= level_d & ~level;
        if (sync_p1 != samp) begin
          cnt <= '0;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (cnt == CNT_ACC) level <= sync_p1;
        end
      end
    end

    assign press[k] = press_r;
  end

  state_t          state;
  logic [PS_W-1:0] presc;
  logic            press_run;
  logic            press_clr;
  logic            run_nxt;

  assign press_run = press[0];
  assign press_clr = press[1];
  // The prescaler follows the state being entered, so a stop freezes it and a resume
  // advances it on the same edge the FSM changes.
  assign run_nxt   = press_run ^ (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STOP;
      presc      <= '0;
      tick_en    <= 1'b0;
      clr_n      <= 1'b1;
      conv_start <= 1'b0;
      running    <= 1'b0;
    end else begin
      conv_start <= tick_en | ~clr_n;
      tick_en    <= 1'b0;
      clr_n      <= 1'b1;
      if (press_clr) begin
        state   <= STOP;
        running <= 1'b0;
        presc   <= '0;
        clr_n   <= 1'b0;
      end else begin
        state   <= run_nxt ? RUN : STOP;
        running <= run_nxt;
        if (run_nxt) begin
          if (presc == PS_MAX) begin
            presc   <= '0;
            tick_en <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with TICK_DIV=4, DB_CYCLES=3; expected timings hand-derived.
module tb_run_ctrl;

  logic clk;
  logic rst_n;
  logic key_run_n;
  logic key_clr_n;
  logic tick_en;
  logic clr_n;
  logic conv_start;
  logic running;

  int total;
  int bad;
  int nt, nc, nclr, nr;

  run_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_run_n  (key_run_n),
    .key_clr_n  (key_clr_n),
    .tick_en    (tick_en),
    .clr_n      (clr_n),
    .conv_start (conv_start),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n edges, counting pulses and RUN cycles observed after each edge.
  task automatic run_cycles(input int n, output int t, output int c, output int cl, output int r);
    t = 0; c = 0; cl = 0; r = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tick_en) t++;
      if (conv_start) c++;
      if (!clr_n) cl++;
      if (running) r++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    step(3);
    chk("rst_tick", 32'(tick_en), 0);
    chk("rst_clr_n", 32'(clr_n), 1);
    chk("rst_conv", 32'(conv_start), 0);
    chk("rst_running", 32'(running), 0);
    rst_n = 1'b1;
    step(5);

    // short glitch on the run key
    key_run_n = 1'b0;
    step(2);
    key_run_n = 1'b1;
    run_cycles(15, nt, nc, nclr, nr);
    chk("glitch_ticks", 32'(nt), 0);
    chk("glitch_running", 32'(nr), 0);

    // clean run press: running rises 7 edges later
    key_run_n = 1'b0;
    step(6);
    chk("run_before", 32'(running), 0);
    step(1);
    chk("run_rise", 32'(running), 1);
    chk("run_rise_tick", 32'(tick_en), 0);
    step(2);
    chk("pre_tick", 32'(tick_en), 0);
    step(1);
    chk("first_tick", 32'(tick_en), 1);
    step(1);
    chk("first_tick_end", 32'(tick_en), 0);
    chk("first_conv", 32'(conv_start), 1);
    step(2);
    chk("gap_conv", 32'(conv_start), 0);
    step(1);
    chk("second_tick", 32'(tick_en), 1);
    key_run_n = 1'b1;
    run_cycles(40, nt, nc, nclr, nr);
    chk("steady_ticks", 32'(nt), 10);
    chk("steady_convs", 32'(nc), 10);
    chk("steady_clrs", 32'(nclr), 0);
    chk("steady_running", 32'(nr), 40);

    // pause with prescaler at 2, then resume
    key_run_n = 1'b0;
    step(7);
    chk("pause_running", 32'(running), 0);
    key_run_n = 1'b1;
    run_cycles(9, nt, nc, nclr, nr);
    chk("pause_ticks", 32'(nt), 0);
    chk("pause_convs", 32'(nc), 0);
    key_run_n = 1'b0;
    run_cycles(6, nt, nc, nclr, nr);
    chk("pause2_ticks", 32'(nt), 0);
    chk("pause2_running", 32'(nr), 0);
    step(1);
    chk("resume_running", 32'(running), 1);
    chk("resume_tick0", 32'(tick_en), 0);
    step(1);
    chk("resume_tick", 32'(tick_en), 1);
    step(1);
    chk("resume_conv", 32'(conv_start), 1);
    chk("resume_tick_end", 32'(tick_en), 0);
    key_run_n = 1'b1;

    // run and clear together when a tick is due
    run_cycles(12, nt, nc, nclr, nr);
    chk("prerace_ticks", 32'(nt), 3);
    key_run_n = 1'b0;
    key_clr_n = 1'b0;
    run_cycles(6, nt, nc, nclr, nr);
    chk("race_wait_ticks", 32'(nt), 1);
    chk("race_wait_clrs", 32'(nclr), 0);
    step(1);
    chk("race_clr_n", 32'(clr_n), 0);
    chk("race_no_tick", 32'(tick_en), 0);
    chk("race_stop", 32'(running), 0);
    step(1);
    chk("race_clr_end", 32'(clr_n), 1);
    chk("race_conv", 32'(conv_start), 1);
    chk("race_tick_after", 32'(tick_en), 0);
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    run_cycles(20, nt, nc, nclr, nr);
    chk("post_race_ticks", 32'(nt), 0);
    chk("post_race_clrs", 32'(nclr), 0);
    chk("post_race_convs", 32'(nc), 0);
    chk("post_race_running", 32'(nr), 0);

    // clear left the prescaler at 0
    key_run_n = 1'b0;
    step(7);
    chk("rerun_running", 32'(running), 1);
    key_run_n = 1'b1;
    key_clr_n = 1'b0;
    step(2);
    chk("rerun_pre_tick", 32'(tick_en), 0);
    step(1);
    chk("rerun_tick", 32'(tick_en), 1);

    // asynchronous reset mid-run and mid-debounce
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick_en), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_clr_n", 32'(clr_n), 1);
    chk("arst_conv", 32'(conv_start), 0);
    step(3);
    key_clr_n = 1'b1;
    rst_n = 1'b1;
    run_cycles(20, nt, nc, nclr, nr);
    chk("idle_ticks", 32'(nt), 0);
    chk("idle_clrs", 32'(nclr), 0);
    chk("idle_convs", 32'(nc), 0);
    chk("idle_running", 32'(nr), 0);

    // key held low across reset release
    key_run_n = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("held_before", 32'(running), 0);
    step(1);
    chk("held_rise", 32'(running), 1);
    run_cycles(30, nt, nc, nclr, nr);
    chk("held_running", 32'(nr), 30);
    chk("held_ticks", 32'(nt), 7);
    key_run_n = 1'b1;
    run_cycles(20, nt, nc, nclr, nr);
    chk("released_running", 32'(nr), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
